// File: rtl/rom_rd_arbiter.sv
// rtl/rom_rd_arbiter.sv - round-robin read arbiter for a shared 2-cycle BRAM ROM
// Optional macro ROM_ARB_PRIO_EN: requester 0 gets strict priority over the round-robin set.
package iu_clk_pkg;
    typedef struct packed {
        logic clk2x;
    } iu_clk_type;
endpackage

module rom_rd_arbiter
    import iu_clk_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int ADDRMSB  = 10,
    parameter int INIT_CYC = 4
) (
    input  iu_clk_type                      gclk,
    input  logic                            rst,
    input  logic [NREQ-1:0]                 req,
    input  logic [NREQ*(ADDRMSB+1)-1:0]     addr,
    input  logic                            halt,
    output logic [NREQ-1:0]                 gnt,
    output logic [NREQ-1:0]                 rvalid,
    output logic [31:0]                     rdata,
    output logic [ADDRMSB:0]                rom_addr,
    output logic                            rom_sr,
    input  logic [31:0]                     rom_dout,
    output logic                            idle
);

    localparam int AW = ADDRMSB + 1;
    localparam int PW = $clog2(NREQ);
`ifdef ROM_ARB_PRIO_EN
    localparam logic [PW-1:0] PTR_WRAP = PW'(1);
`else
    localparam logic [PW-1:0] PTR_WRAP = '0;
`endif

    typedef enum logic {INIT, RUN} state_t;

    logic           clk;
    state_t         state, state_nxt;
    logic [3:0]     cnt, cnt_nxt;
    logic [PW-1:0]  ptr, ptr_nxt;
    logic           v0, v1;
    logic [PW-1:0]  t0, t1;
    logic [AW-1:0]  addr_q;
    logic [NREQ-1:0] rr_req;
    logic           rr_found;
    logic [PW-1:0]  rr_idx;
    logic [PW-1:0]  srch_idx;
    logic           gnt_any;
    logic [PW-1:0]  gidx;

    assign clk = gclk.clk2x;

    // Search from the pointer upward with wrap; bit 0 is excluded when it has its own priority path.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        srch_idx = '0;
`ifdef ROM_ARB_PRIO_EN
        rr_req = {req[NREQ-1:1], 1'b0};
`else
        rr_req = req;
`endif
        for (int k = 0; k < NREQ; k++) begin
            srch_idx = PW'((int'(ptr) + k) % NREQ);
            if (!rr_found && rr_req[srch_idx]) begin
                rr_found = 1'b1;
                rr_idx   = srch_idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        gnt_any   = 1'b0;
        gidx      = '0;
        rom_sr    = 1'b0;
        gnt       = '0;
        case (state)
            INIT: begin
                rom_sr = 1'b1;
                if (cnt == 4'd0) state_nxt = RUN;
                else             cnt_nxt   = cnt - 4'd1;
            end
            RUN: begin
                if (!halt) begin
`ifdef ROM_ARB_PRIO_EN
                    if (req[0]) begin
                        gnt_any = 1'b1;
                        gidx    = '0;
                    end else
`endif
                    if (rr_found) begin
                        gnt_any = 1'b1;
                        gidx    = rr_idx;
                        ptr_nxt = (rr_idx == PW'(NREQ - 1)) ? PTR_WRAP : rr_idx + PW'(1);
                    end
                end
            end
            default: state_nxt = INIT;
        endcase
        if (gnt_any) gnt[gidx] = 1'b1;
    end

    assign rom_addr = gnt_any ? addr[int'(gidx)*AW +: AW] : addr_q;
    assign rdata    = rom_dout;
    assign idle     = (state == RUN) && !gnt_any && !v0 && !v1;

    always_comb begin
        rvalid = '0;
        if (v1) rvalid[t1] = 1'b1;
    end

    // Tag stages mirror the ROM's array and output-register delays.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= INIT;
            cnt    <= 4'(INIT_CYC - 1);
            ptr    <= '0;
            v0     <= 1'b0;
            v1     <= 1'b0;
            t0     <= '0;
            t1     <= '0;
            addr_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ptr    <= ptr_nxt;
            v0     <= gnt_any;
            t0     <= gidx;
            v1     <= v0;
            t1     <= t0;
            addr_q <= rom_addr;
        end
    end

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// tb/tb_rom_rd_arbiter.sv - table-driven scoreboard bench for rom_rd_arbiter
module tb_rom_rd_arbiter;
    import iu_clk_pkg::*;

    logic        clk;
    iu_clk_type  gclk;
    logic        rst;
    logic [3:0]  req;
    logic [43:0] addr;
    logic        halt;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [31:0] rdata;
    logic [10:0] rom_addr;
    logic        rom_sr;
    logic [31:0] rom_dout;
    logic        idle;
    logic [31:0] rom_r1;

    typedef struct {
        logic [3:0] req;
        logic       halt;
        logic [3:0] gnt;
        logic       sr;
        int         idle;
    } vec_t;

    typedef struct {
        int          due;
        logic [3:0]  rv;
        logic [31:0] data;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sbq[$];
    logic [10:0] a[4];
    int          cyc;
    int          n_cmp;
    int          n_err;

    assign gclk.clk2x = clk;

    rom_rd_arbiter #(.NREQ(4), .ADDRMSB(10), .INIT_CYC(4)) dut (
        .gclk(gclk), .rst(rst), .req(req), .addr(addr), .halt(halt),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .rom_addr(rom_addr),
        .rom_sr(rom_sr), .rom_dout(rom_dout), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_f(input logic [10:0] ad);
        return (ad == 11'd5) ? 32'hDEADBEEF : {16'hC0DE, 5'b0, ad};
    endfunction

    // Behavioural ROM: array read then SSR-capable output register.
    always @(posedge clk) begin
        rom_r1   <= rom_f(rom_addr);
        rom_dout <= rom_sr ? 32'h0 : rom_r1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_rv();
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            chk("rvalid", {28'b0, rvalid}, {28'b0, sbq[0].rv});
            chk("rdata", rdata, sbq[0].data);
            void'(sbq.pop_front());
        end else begin
            chk("rvalid_quiet", {28'b0, rvalid}, 32'h0);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic h, input logic [3:0] eg,
                        input logic esr, input int eidle);
        int gi;
        req  = r;
        halt = h;
        addr = {a[3], a[2], a[1], a[0]};
        #1;
        chk("gnt", {28'b0, gnt}, {28'b0, eg});
        chk("rom_sr", {31'b0, rom_sr}, {31'b0, esr});
        if (eidle >= 0) chk("idle", {31'b0, idle}, 32'(eidle));
        if (eg != 4'b0) begin
            gi = 0;
            for (int i = 0; i < 4; i++) if (eg[i]) gi = i;
            chk("rom_addr", {21'b0, rom_addr}, {21'b0, a[gi]});
            sbq.push_back('{due: cyc + 2, rv: eg, data: rom_f(a[gi])});
            a[gi] = a[gi] + 11'd13;
        end
        @(posedge clk);
        cyc++;
        #1;
        check_rv();
    endtask

    task automatic add(input logic [3:0] r, input logic h, input logic [3:0] eg,
                       input logic esr, input int eidle);
        tbl.push_back('{req: r, halt: h, gnt: eg, sr: esr, idle: eidle});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        a[0] = 11'd5; a[1] = 11'h100; a[2] = 11'h200; a[3] = 11'h7F0;
        rst  = 1'b0;
        req  = 4'b0001;
        halt = 1'b0;
        addr = {a[3], a[2], a[1], a[0]};

        // Power-up INIT, then first grant to requester 0 (ROM[5]).
        for (int i = 0; i < 4; i++) add(4'b0001, 1'b0, 4'b0000, 1'b1, 0);
        add(4'b0001, 1'b0, 4'b0001, 1'b0, 0);
        // Walk the pointer back to 0.
        add(4'b0010, 1'b0, 4'b0010, 1'b0, 0);
        add(4'b0100, 1'b0, 4'b0100, 1'b0, 0);
        add(4'b1000, 1'b0, 4'b1000, 1'b0, 0);
`ifdef ROM_ARB_PRIO_EN
        for (int i = 0; i < 4; i++) add(4'b1011, 1'b0, 4'b0001, 1'b0, 0);
        for (int i = 0; i < 2; i++) begin
            add(4'b1010, 1'b0, 4'b0010, 1'b0, 0);
            add(4'b1010, 1'b0, 4'b1000, 1'b0, 0);
        end
`else
        for (int i = 0; i < 2; i++) begin
            add(4'b1111, 1'b0, 4'b0001, 1'b0, 0);
            add(4'b1111, 1'b0, 4'b0010, 1'b0, 0);
            add(4'b1111, 1'b0, 4'b0100, 1'b0, 0);
            add(4'b1111, 1'b0, 4'b1000, 1'b0, 0);
        end
`endif
        add(4'b0110, 1'b0, 4'b0010, 1'b0, 0);
        add(4'b0110, 1'b0, 4'b0100, 1'b0, 0);

        @(posedge clk);
        #1;
        chk("rst_gnt", {28'b0, gnt}, 32'h0);
        chk("rst_rvalid", {28'b0, rvalid}, 32'h0);
        chk("rst_rom_addr", {21'b0, rom_addr}, 32'h0);
        chk("rst_rom_sr", {31'b0, rom_sr}, 32'h1);
        chk("rst_idle", {31'b0, idle}, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].req, tbl[i].halt, tbl[i].gnt, tbl[i].sr, tbl[i].idle);

        // Halt with two reads in flight: they drain, then idle rises.
        step(4'b1111, 1'b1, 4'b0000, 1'b0, 0);
        step(4'b1111, 1'b1, 4'b0000, 1'b0, 0);
        step(4'b1111, 1'b1, 4'b0000, 1'b0, 1);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1);

        // Reset the cycle after a grant: the read must never return.
        step(4'b0100, 1'b0, 4'b0100, 1'b0, 0);
        rst = 1'b0;
        sbq.delete();
        #1;
        chk("mid_rst_gnt", {28'b0, gnt}, 32'h0);
        chk("mid_rst_rom_sr", {31'b0, rom_sr}, 32'h1);
        chk("mid_rst_rvalid", {28'b0, rvalid}, 32'h0);
        chk("mid_rst_rom_addr", {21'b0, rom_addr}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            chk("mid_rst_rvalid_hold", {28'b0, rvalid}, 32'h0);
            chk("mid_rst_sr_hold", {31'b0, rom_sr}, 32'h1);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step(4'b1000, 1'b0, 4'b0000, 1'b1, 0);
        step(4'b1000, 1'b0, 4'b1000, 1'b0, 0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1);

        if (sbq.size() != 0) chk("scoreboard_empty", 32'(sbq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rom_rd_arbiter.md
Name: rom_rd_arbiter

Overview:
- Shares one 32-bit BRAM ROM (xcv5 ROM, 2-cycle read latency: BRAM array + DOA output register) among NREQ requesters, e.g. per-pipeline fetch, debug, and DMA boot copy.
- Runs a post-reset init sequence that holds the ROM output register in reset.
- Round-robin grants at most one read per cycle.
- Tracks in-flight reads with a tag pipeline so each returned word is steered to its requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADDRMSB, 10, ROM word-address MSB; matches the ROM instance.
- INIT_CYC, 4, cycles `rom_sr` is held high after reset release (1..15).

Ports:
- `gclk`  input  iu_clk_type  clock bundle; all logic clocked on `gclk.clk2x`, same clock as the ROM.
- `rst`  input  1  asynchronous, active-low reset.
- `req`  input  NREQ  per-requester read request, level; held until granted.
- `addr`  input  NREQ*(ADDRMSB+1)  flattened word addresses; slice i belongs to requester i.
- `halt`  input  1  blocks new grants; in-flight reads still complete.
- `gnt`  output  NREQ  one-hot grant, combinational, same cycle as accepted `req`.
- `rvalid`  output  NREQ  one-hot, one cycle, marks `rdata` valid for that requester.
- `rdata`  output  32  shared read data; equals `rom_dout`.
- `rom_addr`  output  ADDRMSB+1  ROM address; granted `addr` slice, else last value held.
- `rom_sr`  output  1  active-high synchronous reset to ROM output register (SSRA).
- `rom_dout`  input  32  ROM data out.
- `idle`  output  1  high when in RUN, no grant this cycle, and tag pipeline empty.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - state=INIT, init counter=INIT_CYC-1, RR pointer=0.
  - Tag pipeline cleared: both stages valid=0.
  - `gnt`=0, `rvalid`=0, `rom_addr`=0, `rom_sr`=1, `idle`=0.
- INIT state:
  - `rom_sr`=1, `gnt`=0.
  - Counter decrements each cycle; on 0, next state=RUN and `rom_sr`=0 from that cycle.
  - `rom_sr` is high for exactly INIT_CYC cycles after reset release.
- RUN state: arbitration.
  - If `halt`=0 and `req`!=0, grant the first set bit searching from RR pointer upward with wrap (NREQ-1 -> 0).
  - RR pointer <= granted index + 1 (mod NREQ).
  - No grant leaves the pointer unchanged.
  - At most one grant per cycle; back-to-back grants to different or the same requester are allowed every cycle.
- Latency:
  - Grant in cycle T: `rom_addr`=addr[g] in T, and the ROM samples it at the end of T.
  - Tag stage0 <= {1,g} at end of T; stage1 <= stage0.
  - `rvalid[g]`=1 in cycle T+2 with `rdata`=ROM[addr[g]].
  - Fixed latency of 2; a throughput of 1 per cycle is sustained.
- Requester rule: `req[i]` and its `addr` are stable until `gnt[i]`; the requester deasserts or presents the next address in the following cycle.
- `halt`:
  - Blocks grants from the cycle it is high.
  - Outstanding tags drain; `idle` rises once both tag stages are empty.
- `rvalid` is only ever driven from the tag pipeline; `rom_sr` never asserts in RUN.
- Reset mid-operation clears in-flight tags; those reads never produce `rvalid`.

Optional Feature:
- Macro: `ROM_ARB_PRIO_EN`.
- Defined: requester 0 has strict priority; any `req[0]` wins. Remaining requesters use round-robin among themselves, and the pointer never selects 0.
- Undefined: pure round-robin over all NREQ as above.

Test Plan:
1. Release reset, INIT_CYC=4 -> `rom_sr` high exactly 4 cycles, `gnt`=0 throughout; first grant possible in cycle 5.
2. `req`=0001, addr0=0x005 (ROM[5]=0xDEADBEEF), granted cycle T -> `rvalid`=0001 at T+2, `rdata`=0xDEADBEEF.
3. `req`=1111 held for 8 cycles, RR pointer 0 -> grant order 0,1,2,3,0,1,2,3; `rvalid` follows the same order 2 cycles later, no gaps.
4. Two grants, then `halt`=1 -> no further `gnt`; both `rvalid` still arrive; `idle`=1 the cycle after the last `rvalid`.
5. Grant at T, `rst` low at T+1 -> no `rvalid` at T+2; INIT re-entered, `rom_sr`=1.
6. With `ROM_ARB_PRIO_EN`, `req`=1011 for 4 cycles -> `gnt`=0001 every cycle. Then `req`=1010 -> grants alternate 1,3.
